// File: rtl/implication_collector.sv
// rtl/implication_collector.sv - collects newly implied LUT pins and streams them as (var, value)
// Optional macro: IMPLICATION_COLLECTOR_STATS_EN adds saturating stat_implications / stat_conflicts counters.
module implication_collector #(
    parameter int LUT_SIZE     = 8,
    parameter int VAR_ID_WIDTH = 16,
    parameter int CNT_WIDTH    = $clog2(LUT_SIZE + 2)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [2*LUT_SIZE+1:0]               pins,
    input  logic [2*LUT_SIZE+1:0]               implied_pins,
    input  logic                                conflict,
    input  logic [(LUT_SIZE+1)*VAR_ID_WIDTH-1:0] pin_vars,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [VAR_ID_WIDTH-1:0]             out_var,
    output logic                                out_value,
    output logic                                done,
    output logic                                done_conflict,
    output logic [CNT_WIDTH-1:0]                done_count,
    output logic                                busy
`ifdef IMPLICATION_COLLECTOR_STATS_EN
    ,
    output logic [31:0]                         stat_implications,
    output logic [31:0]                         stat_conflicts
`endif
);

    localparam int NPINS = LUT_SIZE + 1;
    localparam int IDX_W = (NPINS > 1) ? $clog2(NPINS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state;
    logic [NPINS-1:0]                mask;
    logic [NPINS-1:0]                value_q;
    logic [NPINS*VAR_ID_WIDTH-1:0]   vars_q;
    logic                            conflict_q;
    logic [CNT_WIDTH-1:0]            count;
    logic [IDX_W-1:0]                cur_idx;

    logic [NPINS-1:0]                new_mask;
    logic [NPINS-1:0]                new_value;
    logic [IDX_W-1:0]                new_idx;
    logic [NPINS-1:0]                rest_mask;
    logic [IDX_W-1:0]                rest_idx;

    // Lowest-index set bit; pin order is inputs first, then the output pin.
    function automatic logic [IDX_W-1:0] lowest(input logic [NPINS-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NPINS - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // A pin is newly assigned when it was UNKNOWN and imply produced a definite 0/1.
    always_comb begin
        new_mask  = '0;
        new_value = '0;
        for (int i = 0; i < NPINS; i++) begin
            new_mask[i]  = (pins[2*i +: 2] == 2'b11) && (implied_pins[2*i+1] == 1'b0);
            new_value[i] = implied_pins[2*i];
        end
    end

    // Candidate selection for the first emission and for the one following a handshake.
    always_comb begin
        new_idx   = lowest(new_mask);
        rest_mask = mask & ~(NPINS'(1) << cur_idx);
        rest_idx  = lowest(rest_mask);
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Main control FSM; all stream and completion outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mask          <= '0;
            value_q       <= '0;
            vars_q        <= '0;
            conflict_q    <= 1'b0;
            count         <= '0;
            cur_idx       <= '0;
            out_valid     <= 1'b0;
            out_var       <= '0;
            out_value     <= 1'b0;
            done          <= 1'b0;
            done_conflict <= 1'b0;
            done_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done          <= 1'b0;
                    done_conflict <= 1'b0;
                    done_count    <= '0;
                    count         <= '0;
                    if (in_valid) begin
                        value_q    <= new_value;
                        vars_q     <= pin_vars;
                        conflict_q <= conflict;
                        if (conflict || (new_mask == '0)) begin
                            // A conflicting evaluation implies nothing, so its mask is dropped.
                            mask          <= '0;
                            state         <= DONE;
                            done          <= 1'b1;
                            done_conflict <= conflict;
                            done_count    <= '0;
                        end else begin
                            mask      <= new_mask;
                            cur_idx   <= new_idx;
                            out_valid <= 1'b1;
                            out_var   <= pin_vars[int'(new_idx)*VAR_ID_WIDTH +: VAR_ID_WIDTH];
                            out_value <= new_value[new_idx];
                            state     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        count <= count + 1'b1;
                        mask  <= rest_mask;
                        if (rest_mask == '0) begin
                            out_valid     <= 1'b0;
                            state         <= DONE;
                            done          <= 1'b1;
                            done_conflict <= conflict_q;
                            done_count    <= count + 1'b1;
                        end else begin
                            // Preload the next pin so emissions continue back to back.
                            cur_idx   <= rest_idx;
                            out_var   <= vars_q[int'(rest_idx)*VAR_ID_WIDTH +: VAR_ID_WIDTH];
                            out_value <= value_q[rest_idx];
                        end
                    end
                end
                DONE: begin
                    done          <= 1'b0;
                    done_conflict <= 1'b0;
                    done_count    <= '0;
                    count         <= '0;
                    state         <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    mask      <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef IMPLICATION_COLLECTOR_STATS_EN
    // Saturating activity counters for emitted implications and conflicting transactions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_implications <= '0;
            stat_conflicts    <= '0;
        end else begin
            if (out_valid && out_ready && (stat_implications != 32'hFFFF_FFFF)) begin
                stat_implications <= stat_implications + 32'd1;
            end
            if (done && done_conflict && (stat_conflicts != 32'hFFFF_FFFF)) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_implication_collector.sv
// tb/tb_implication_collector.sv - directed self-checking bench for implication_collector
module tb_implication_collector;

    localparam int LUT_SIZE     = 8;
    localparam int VAR_ID_WIDTH = 16;
    localparam int CNT_WIDTH    = $clog2(LUT_SIZE + 2);
    localparam int NPINS        = LUT_SIZE + 1;

    logic                              clk;
    logic                              reset;
    logic                              in_valid;
    logic                              in_ready;
    logic [2*LUT_SIZE+1:0]             pins;
    logic [2*LUT_SIZE+1:0]             implied_pins;
    logic                              conflict;
    logic [NPINS*VAR_ID_WIDTH-1:0]     pin_vars;
    logic                              out_valid;
    logic                              out_ready;
    logic [VAR_ID_WIDTH-1:0]           out_var;
    logic                              out_value;
    logic                              done;
    logic                              done_conflict;
    logic [CNT_WIDTH-1:0]              done_count;
    logic                              busy;
`ifdef IMPLICATION_COLLECTOR_STATS_EN
    logic [31:0]                       stat_implications;
    logic [31:0]                       stat_conflicts;
`endif

    int n_vec;
    int n_err;

    implication_collector #(
        .LUT_SIZE    (LUT_SIZE),
        .VAR_ID_WIDTH(VAR_ID_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pins         (pins),
        .implied_pins (implied_pins),
        .conflict     (conflict),
        .pin_vars     (pin_vars),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_var      (out_var),
        .out_value    (out_value),
        .done         (done),
        .done_conflict(done_conflict),
        .done_count   (done_count),
        .busy         (busy)
`ifdef IMPLICATION_COLLECTOR_STATS_EN
        ,
        .stat_implications(stat_implications),
        .stat_conflicts   (stat_conflicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pin code vector: pin0, pin1, pins 2..7 all 'rest', pin8.
    function automatic logic [2*LUT_SIZE+1:0] mk(input logic [1:0] p0, input logic [1:0] p1,
                                                 input logic [1:0] rest, input logic [1:0] p8);
        return {p8, {6{rest}}, p1, p0};
    endfunction

    function automatic logic [NPINS*VAR_ID_WIDTH-1:0] mk_vars(input int base);
        logic [NPINS*VAR_ID_WIDTH-1:0] v;
        for (int i = 0; i < NPINS; i++) v[i*VAR_ID_WIDTH +: VAR_ID_WIDTH] = 16'(base + i);
        return v;
    endfunction

    // Present one transaction, let edge N accept it, return at the negedge of cycle N+1.
    task automatic send(input logic [2*LUT_SIZE+1:0] p, input logic [2*LUT_SIZE+1:0] ip,
                        input logic c);
        pins         = p;
        implied_pins = ip;
        conflict     = c;
        pin_vars     = mk_vars(100);
        in_valid     = 1'b1;
        @(posedge clk);
        #1 in_valid  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        pins         = '0;
        implied_pins = '0;
        conflict     = 1'b0;
        pin_vars     = mk_vars(100);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_var", 32'(out_var), 0);
        check("rst_done_count", 32'(done_count), 0);
        reset = 1'b0;
        @(negedge clk);

        // AND implication: in0,in1 unknown -> both implied 1
        send(mk(2'b11, 2'b11, 2'b00, 2'b01), mk(2'b01, 2'b01, 2'b00, 2'b01), 1'b0);
        check("and_v1", 32'(out_valid), 1);
        check("and_var1", 32'(out_var), 100);
        check("and_val1", 32'(out_value), 1);
        check("and_in_ready", 32'(in_ready), 0);
        check("and_busy", 32'(busy), 1);
        @(negedge clk);
        check("and_v2", 32'(out_valid), 1);
        check("and_var2", 32'(out_var), 101);
        check("and_val2", 32'(out_value), 1);
        @(negedge clk);
        check("and_done", 32'(done), 1);
        check("and_done_cnt", 32'(done_count), 2);
        check("and_done_cf", 32'(done_conflict), 0);
        check("and_v_off", 32'(out_valid), 0);
        @(negedge clk);
        check("and_done_off", 32'(done), 0);
        check("and_idle_rdy", 32'(in_ready), 1);

        // Conflict: same mask, but conflict flag set
        send(mk(2'b11, 2'b11, 2'b00, 2'b01), mk(2'b01, 2'b01, 2'b00, 2'b01), 1'b1);
        check("cf_out_valid", 32'(out_valid), 0);
        check("cf_done", 32'(done), 1);
        check("cf_done_cf", 32'(done_conflict), 1);
        check("cf_done_cnt", 32'(done_count), 0);
        @(negedge clk);
        check("cf_out_valid2", 32'(out_valid), 0);

        // Nothing new; pin code 10 counts as not-unknown, implied 11 is no implication
        send(mk(2'b10, 2'b11, 2'b00, 2'b01), mk(2'b01, 2'b11, 2'b00, 2'b01), 1'b0);
        check("none_done", 32'(done), 1);
        check("none_cnt", 32'(done_count), 0);
        check("none_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("none_in_ready", 32'(in_ready), 1);

        // Backpressure with an ignored concurrent transaction
        out_ready = 1'b0;
        send(mk(2'b11, 2'b11, 2'b00, 2'b01), mk(2'b01, 2'b01, 2'b00, 2'b01), 1'b0);
        pins         = mk(2'b00, 2'b00, 2'b00, 2'b11);
        implied_pins = mk(2'b00, 2'b00, 2'b00, 2'b00);
        pin_vars     = mk_vars(500);
        in_valid     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(out_valid), 1);
            check("bp_var", 32'(out_var), 100);
            check("bp_val", 32'(out_value), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_hold_var", 32'(out_var), 100);
        @(negedge clk);
        check("bp_var2", 32'(out_var), 101);
        check("bp_valid2", 32'(out_valid), 1);
        @(negedge clk);
        check("bp_done", 32'(done), 1);
        check("bp_cnt", 32'(done_count), 2);
        @(negedge clk);
        check("bp_no_capture", 32'(busy), 0);

        // Output-pin implication
        send(mk(2'b01, 2'b00, 2'b00, 2'b11), mk(2'b01, 2'b00, 2'b00, 2'b00), 1'b0);
        check("op_valid", 32'(out_valid), 1);
        check("op_var", 32'(out_var), 108);
        check("op_val", 32'(out_value), 0);
        @(negedge clk);
        check("op_done", 32'(done), 1);
        check("op_cnt", 32'(done_count), 1);
        @(negedge clk);

        // Reset mid-EMIT after the first handshake
        send(mk(2'b11, 2'b11, 2'b00, 2'b01), mk(2'b01, 2'b01, 2'b00, 2'b01), 1'b0);
        @(negedge clk);
        check("mr_var2", 32'(out_var), 101);
        #2 reset = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 0);
        check("mr_busy", 32'(busy), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mr_no_done", 32'(done), 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("mr_in_ready", 32'(in_ready), 1);
        check("mr_done_after", 32'(done), 0);
        check("mr_out_valid2", 32'(out_valid), 0);
`ifdef IMPLICATION_COLLECTOR_STATS_EN
        check("mr_stat_impl", stat_implications, 0);
        check("mr_stat_cf", stat_conflicts, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/implication_collector.md
Name: implication_collector

Overview:
- Downstream consumer of the combinational LUT implication stage (imply) in the hardware CSAT propagation path.
- Accepts one evaluation result per transaction:
  - original pin assignments, implied pins, conflict flag
  - the global variable ID bound to each pin
- Extracts the pins that became newly assigned and emits them one per cycle as (variable, value) over a valid/ready stream to the trail/propagation queue.
- Reports completion, conflict and implication count per transaction.

Parameters:
- LUT_SIZE, 8, LUT inputs; pin count is LUT_SIZE+1 (pins 0..LUT_SIZE-1 are inputs, pin LUT_SIZE is the output).
- VAR_ID_WIDTH, 16, width of one global variable ID.
- CNT_WIDTH, $clog2(LUT_SIZE+2), width of the implication count.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  result transaction valid
- in_ready  output  1  collector can accept a transaction
- pins  input  2*LUT_SIZE+2  pre-imply assignments, 2 bits per pin (00=ZERO, 01=ONE, 11=UNKNOWN)
- implied_pins  input  2*LUT_SIZE+2  imply output, same encoding
- conflict  input  1  imply conflict flag
- pin_vars  input  (LUT_SIZE+1)*VAR_ID_WIDTH  variable ID per pin; pin i occupies bits [i*VAR_ID_WIDTH +: VAR_ID_WIDTH]
- out_valid  output  1  implication available
- out_ready  input  1  downstream accepts implication
- out_var  output  VAR_ID_WIDTH  variable ID of the implication
- out_value  output  1  implied value (0/1)
- done  output  1  one-cycle pulse, transaction finished
- done_conflict  output  1  valid with done; captured conflict
- done_count  output  CNT_WIDTH  valid with done; implications emitted
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, active-high): FSM=IDLE, mask=0, count=0. Outputs: out_valid=0, done=0, done_conflict=0, done_count=0, busy=0, in_ready=1, out_var=0, out_value=0.
- Reset asserted mid-transaction aborts it immediately. Nothing more is emitted and no done pulse is produced.
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register implied_pins, pin_vars and conflict.
  - Build new-mask: bit i=1 iff pins[i]==11 and implied_pins[i] is 00 or 01.
  - pins code 10 is treated as not-unknown. implied code 10/11 is never an implication.
  - Next state: conflict=1 -> DONE, mask discarded. Mask==0 -> DONE. Otherwise -> EMIT.
- EMIT:
  - out_valid=1.
  - out_var/out_value are taken from the lowest-index set mask bit: out_value = implied bit 0 of that pin.
  - Outputs are driven from registered state only and stay stable while out_valid&&!out_ready.
  - On out_valid&&out_ready, clear that bit and increment count.
  - When the final bit is consumed -> DONE. There is no idle cycle between successive emissions.
- DONE:
  - For one cycle: done=1, done_conflict=captured conflict, done_count=count.
  - Then -> IDLE, clearing count.
  - done_count=0 whenever conflict=1.
- in_ready=0 in EMIT and DONE. in_valid is ignored there, with no capture.
- Latency, with the transaction accepted at edge N:
  - First out_valid in cycle N+1.
  - With out_ready held high, k implications occupy cycles N+1..N+k and done occurs at N+k+1.
  - For conflict or empty mask, done occurs at N+1.
- Next acceptance is possible at the cycle after done. Maximum throughput is one transaction per k+2 cycles.
- Pin order is inputs 0..LUT_SIZE-1 first, then the output pin LUT_SIZE.

Optional Feature:
- Macro: IMPLICATION_COLLECTOR_STATS_EN.
- Defined:
  - Adds output ports stat_implications [31:0] and stat_conflicts [31:0].
  - Both are saturating counters, reset to 0 by reset.
  - stat_implications increments on every out handshake.
  - stat_conflicts increments on every done with done_conflict=1.
  - Both hold at 32'hFFFFFFFF.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Common setup: LUT_SIZE=8, VAR_ID_WIDTH=16, pin_vars pin i = 100+i.
- AND implication: pins in0=11, in1=11, out=01, rest 00; implied in0=01, in1=01; out_ready=1 -> out (100,1) at N+1, (101,1) at N+2, done at N+3 with count=2, conflict=0.
- Conflict: same mask but conflict=1 -> out_valid never asserts; done=1, done_conflict=1, done_count=0 at N+1.
- Nothing new: pins==implied_pins, conflict=0 -> done at N+1 with count=0; in_ready=1 at N+2.
- Backpressure: AND case with out_ready=0 for 3 cycles -> out_var=100, out_value=1 held stable; in_ready=0; a concurrent in_valid is not captured; emission resumes when out_ready=1.
- Output-pin implication: inputs assigned, pin 8=11, implied pin 8=00 -> single emit (108,0), done_count=1.
- Reset mid-EMIT: assert reset after first handshake -> out_valid=0 and busy=0 asynchronously; no done pulse; in_ready=1 after release; with STATS_EN, counters read 0.
